// File: rtl/sram_mst_pkg.sv
// rtl/sram_mst_pkg.sv - shared FSM states, read-token type and default widths for the SRAM burst master
package sram_mst_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One token travels alongside each issued read address.
    typedef struct packed {
        logic valid;
        logic last;
    } rd_tok_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - DEPTH-stage shift register of read tokens matching the SRAM read latency
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear
//   in_tok     : token entering stage 0 every cycle
//   out_tok    : token leaving the last stage (aligned with sram_dout)
//   empty      : no stage holds a valid token
module sram_rd_pipe
    import sram_mst_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tok_t in_tok,
    output rd_tok_t out_tok,
    output logic    empty
);

    rd_tok_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tok;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i].valid) begin
                empty = 1'b0;
            end
        end
    end

    assign out_tok = stage[DEPTH-1];

endmodule

// File: rtl/sram_burst_master.sv
// rtl/sram_burst_master.sv - burst read/write initiator driving a single-port SRAM one beat per cycle
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   req_valid/req_ready/req_wr/req_addr/req_len : burst command channel (beats = req_len+1)
//   wr_valid/wr_ready/wr_data     : write beat stream
//   rd_valid/rd_data/rd_last      : read beat return, no backpressure
//   busy                          : registered, state != IDLE
//   sram_wren/sram_addr/sram_din/sram_dout : SRAM port
module sram_burst_master
    import sram_mst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              sram_wren,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic              last_beat;
    logic              req_ready_c;
    logic              wr_ready_c;
    rd_tok_t           issue_tok;
    rd_tok_t           ret_tok;
    logic              pipe_empty;

    assign last_beat = (beat_cnt == '0);

    always_comb begin
        next_state  = state;
        req_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    next_state = req_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready_c = 1'b1;
                if (wr_valid && last_beat) begin
                    next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_beat) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // issue_tok is the first slot of the return pipe (it rides with sram_addr)
                if (pipe_empty && !issue_tok.valid) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            addr_cnt  <= '0;
            beat_cnt  <= '0;
            sram_wren <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            issue_tok <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != ST_IDLE);
            sram_wren <= 1'b0;
            issue_tok <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_cnt <= req_addr;
                        beat_cnt <= req_len;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        sram_wren <= 1'b1;
                        sram_addr <= addr_cnt;
                        sram_din  <= wr_data;
                        addr_cnt  <= addr_cnt + 1'b1;
                        beat_cnt  <= beat_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    sram_addr       <= addr_cnt;
                    issue_tok.valid <= 1'b1;
                    issue_tok.last  <= last_beat;
                    addr_cnt        <= addr_cnt + 1'b1;
                    beat_cnt        <= beat_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    sram_rd_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .in_tok  (issue_tok),
        .out_tok (ret_tok),
        .empty   (pipe_empty)
    );

    // Gate with rst so the command channel reads 0 while reset is held.
    assign req_ready = req_ready_c & rst;
    assign wr_ready  = wr_ready_c;
    assign rd_valid  = ret_tok.valid;
    assign rd_last   = ret_tok.valid & ret_tok.last;
    assign rd_data   = ret_tok.valid ? sram_dout : '0;

endmodule

// File: tb/tb_sram_burst_master.sv
// tb/tb_sram_burst_master.sv - directed self-checking bench for sram_burst_master
module tb_sram_burst_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       sram_wren;
    logic [7:0] sram_addr;
    logic [7:0] sram_din;
    logic [7:0] sram_dout = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] mem [256];
    logic [7:0] wlog_a [$];
    logic [7:0] wlog_d [$];
    int         wlog_c [$];
    logic [7:0] rlog_d [$];
    logic       rlog_l [$];
    int         rlog_c [$];

    sram_burst_master #(
        .ADDR_W (8),
        .DATA_W (8),
        .LEN_W  (4),
        .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .sram_wren (sram_wren),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM, one cycle read latency.
    always @(posedge clk) begin
        if (sram_wren) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    always @(negedge clk) begin
        if (sram_wren) begin
            wlog_a.push_back(sram_addr);
            wlog_d.push_back(sram_din);
            wlog_c.push_back(cyc);
        end
        if (rd_valid) begin
            rlog_d.push_back(rd_data);
            rlog_l.push_back(rd_last);
            rlog_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        rlog_d.delete(); rlog_l.delete(); rlog_c.delete();
    endtask

    task automatic do_req(input logic wr, input logic [7:0] a, input logic [3:0] l);
        logic hs;
        int   n;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        acc_cyc = cyc;
        chk("req_accept", {31'd0, hs}, 32'd1);
    endtask

    task automatic write_beats(input int n, input logic [7:0] d0, input int stall_after, input int stall_n);
        logic hs;
        int   g;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = d0 + 8'(i);
            hs = 1'b0; g = 0;
            while (!hs && g < 50) begin
                @(negedge clk);
                hs = wr_ready;
                tick();
                g++;
            end
            if (!hs) chk("wr_beat_timeout", 32'd0, 32'd1);
            if (i + 1 == stall_after) begin
                wr_valid = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_busy", {31'd0, busy}, 32'd1);
                    tick();
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        repeat (3) tick();
    endtask

    task automatic check_read(input string tag, input int n, input logic [7:0] d0);
        chk({tag, "_count"}, rlog_d.size(), n);
        for (int i = 0; i < n && i < rlog_d.size(); i++) begin
            chk({tag, "_data"}, rlog_d[i], d0 + 8'(i));
            chk({tag, "_last"}, {31'd0, rlog_l[i]}, (i == n - 1) ? 32'd1 : 32'd0);
            chk({tag, "_b2b"}, rlog_c[i], rlog_c[0] + i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a [4];
        int hs, rdy_bad, g;
        logic fire;

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;

        // Reset state
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_sram_wren", {31'd0, sram_wren}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Single write then single read
        clear_logs();
        do_req(1'b1, 8'h10, 4'd0);
        write_beats(1, 8'hA5, 0, 0);
        wait_idle();
        chk("single_wr_count", wlog_a.size(), 1);
        if (wlog_a.size() > 0) begin
            chk("single_wr_addr", wlog_a[0], 8'h10);
            chk("single_wr_data", wlog_d[0], 8'hA5);
        end
        clear_logs();
        do_req(1'b0, 8'h10, 4'd0);
        wait_idle();
        check_read("single_rd", 1, 8'hA5);
        if (rlog_c.size() > 0) chk("single_rd_latency", rlog_c[0], acc_cyc + 2);

        // 16-beat burst
        clear_logs();
        do_req(1'b1, 8'h20, 4'd15);
        write_beats(16, 8'h00, 0, 0);
        wait_idle();
        chk("burst_wr_count", wlog_a.size(), 16);
        for (int i = 0; i < 16 && i < wlog_a.size(); i++) begin
            chk("burst_wr_addr", wlog_a[i], 8'h20 + 8'(i));
            chk("burst_wr_data", wlog_d[i], 8'(i));
        end
        clear_logs();
        do_req(1'b0, 8'h20, 4'd15);
        wait_idle();
        check_read("burst_rd", 16, 8'h00);

        // Address wrap
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        clear_logs();
        do_req(1'b1, 8'hFE, 4'd3);
        write_beats(4, 8'h50, 0, 0);
        wait_idle();
        chk("wrap_wr_count", wlog_a.size(), 4);
        for (int i = 0; i < 4 && i < wlog_a.size(); i++) chk("wrap_wr_addr", wlog_a[i], exp_a[i]);
        clear_logs();
        do_req(1'b0, 8'hFE, 4'd3);
        wait_idle();
        check_read("wrap_rd", 4, 8'h50);

        // Write stall of 3 cycles after beat 2
        clear_logs();
        do_req(1'b1, 8'h40, 4'd5);
        write_beats(6, 8'h60, 2, 3);
        wait_idle();
        chk("stall_wr_count", wlog_a.size(), 6);
        for (int i = 0; i < 6 && i < wlog_a.size(); i++) begin
            chk("stall_wr_addr", wlog_a[i], 8'h40 + 8'(i));
            chk("stall_wr_data", wlog_d[i], 8'h60 + 8'(i));
        end
        if (wlog_c.size() == 6) begin
            chk("stall_gap", wlog_c[2] - wlog_c[1], 4);
            chk("stall_span", wlog_c[5] - wlog_c[0], 8);
        end

        // Request held while busy
        clear_logs();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h20; req_len = 4'd7;
        hs = 0; rdy_bad = 0; g = 0;
        while (hs < 2 && g < 80) begin
            @(negedge clk);
            if (busy && req_ready) rdy_bad++;
            fire = req_valid && req_ready;
            tick();
            g++;
            if (fire) begin
                hs++;
                if (hs == 1) begin
                    req_addr = 8'h10; req_len = 4'd0;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        wait_idle();
        chk("busy_hs_count", hs, 2);
        chk("busy_ready_low", rdy_bad, 0);
        chk("busy_rd_count", rlog_d.size(), 9);
        for (int i = 0; i < 8 && i < rlog_d.size(); i++) begin
            chk("busy_rd_data", rlog_d[i], 8'(i));
            chk("busy_rd_last", {31'd0, rlog_l[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        if (rlog_d.size() == 9) begin
            chk("busy_rd2_data", rlog_d[8], 8'hA5);
            chk("busy_rd2_last", {31'd0, rlog_l[8]}, 32'd1);
        end

        // Reset mid-burst on beat 3 of 8
        clear_logs();
        do_req(1'b1, 8'h80, 4'd7);
        write_beats(3, 8'h90, 0, 0);
        wr_valid = 1'b1; wr_data = 8'h93;
        rst = 1'b0;
        #1;
        chk("mid_rst_sram_wren", {31'd0, sram_wren}, 32'd0);
        chk("mid_rst_sram_addr", sram_addr, 8'h00);
        chk("mid_rst_sram_din", sram_din, 8'h00);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_release_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_release_wr_ready", {31'd0, wr_ready}, 32'd0);
        repeat (5) tick();
        wr_valid = 1'b0;
        chk("mid_rst_wr_count", wlog_a.size(), 2);
        chk("mid_rst_mem80", mem[8'h80], 8'h90);
        chk("mid_rst_mem81", mem[8'h81], 8'h91);
        for (int i = 3; i < 8; i++) chk("mid_rst_untouched", mem[8'h80 + i], 8'hEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
